// File: rtl/approx_add_if.sv
// Operand/result stream interface for approx_add_pipe.
// The master drives the operand beat and out_ready. The slave (the adder) drives the result beat.
interface approx_add_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   O;
    logic [WIDTH:0]   out_err;

    modport master (
        output in_valid, A, B, mode, out_ready,
        input  in_ready, out_valid, O, out_err
    );

    modport slave (
        input  in_valid, A, B, mode, out_ready,
        output in_ready, out_valid, O, out_err
    );
endinterface

// File: rtl/approx_add_pipe.sv
// Pipelined lower-part-approximate unsigned adder with per-beat exact/approximate mode,
// valid/ready flow control and an on-line error statistics monitor.
module approx_add_pipe #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 4,
    parameter int STAGES      = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    approx_add_if.slave      bus,
    input  logic             clear_stats,
    output logic [WIDTH:0]   max_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] txn_cnt
);
    localparam int K    = APPROX_BITS;
    localparam int LAST = STAGES - 1;

    logic [WIDTH:0]   exact_s;
    logic [WIDTH:0]   approx_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   err_s;
    logic             en_s;
    logic             hs_s;

    logic             valid_r [STAGES];
    logic [WIDTH:0]   sum_r   [STAGES];
    logic [WIDTH:0]   exact_r [STAGES];
    logic             mode_r  [STAGES];

    logic [WIDTH:0]   max_err_r;
    logic [CNT_W-1:0] err_cnt_r;
    logic [CNT_W-1:0] txn_cnt_r;

    function automatic logic [WIDTH:0] abs_diff(input logic [WIDTH:0] x, input logic [WIDTH:0] y);
        logic [WIDTH:0] d;
        if (x >= y) begin
            d = x - y;
        end else begin
            d = y - x;
        end
        return d;
    endfunction

    assign exact_s = {1'b0, bus.A} + {1'b0, bus.B};

    generate
        if (K == 0) begin : g_exact_only
            assign approx_s = exact_s;
        end else begin : g_lower_part
            logic [WIDTH-K:0] hi_s;
            logic             carry_s;
            // The low K bits pass A through; only their top bit pair predicts the carry.
            assign carry_s  = bus.A[K-1] & bus.B[K-1];
            assign hi_s     = {1'b0, bus.A[WIDTH-1:K]} + {1'b0, bus.B[WIDTH-1:K]}
                            + {{(WIDTH-K){1'b0}}, carry_s};
            assign approx_s = {hi_s, bus.A[K-1:0]};
        end
    endgenerate

    assign sum_s        = bus.mode ? approx_s : exact_s;
    assign en_s         = !valid_r[LAST] || bus.out_ready;
    assign bus.in_ready = en_s;
    assign hs_s         = valid_r[LAST] && bus.out_ready;
    assign err_s        = mode_r[LAST] ? abs_diff(exact_r[LAST], sum_r[LAST]) : {(WIDTH+1){1'b0}};

    assign bus.out_valid = valid_r[LAST];
    assign bus.O         = sum_r[LAST];
    assign bus.out_err   = err_s;
    assign max_err       = max_err_r;
    assign err_cnt       = err_cnt_r;
    assign txn_cnt       = txn_cnt_r;

    // Pipeline registers: the whole pipe advances together or holds together.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                valid_r[i] <= 1'b0;
                sum_r[i]   <= {(WIDTH+1){1'b0}};
                exact_r[i] <= {(WIDTH+1){1'b0}};
                mode_r[i]  <= 1'b0;
            end
        end else if (en_s) begin
            valid_r[0] <= bus.in_valid;
            sum_r[0]   <= sum_s;
            exact_r[0] <= exact_s;
            mode_r[0]  <= bus.mode;
            for (int i = 1; i < STAGES; i++) begin
                valid_r[i] <= valid_r[i-1];
                sum_r[i]   <= sum_r[i-1];
                exact_r[i] <= exact_r[i-1];
                mode_r[i]  <= mode_r[i-1];
            end
        end
    end

    // Error statistics, updated on each output handshake; a clear in the same cycle wins.
    always_ff @(posedge clk) begin
        if (rst || clear_stats) begin
            max_err_r <= {(WIDTH+1){1'b0}};
            err_cnt_r <= {CNT_W{1'b0}};
            txn_cnt_r <= {CNT_W{1'b0}};
        end else if (hs_s) begin
            if (txn_cnt_r != {CNT_W{1'b1}}) begin
                txn_cnt_r <= txn_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if ((err_s != {(WIDTH+1){1'b0}}) && (err_cnt_r != {CNT_W{1'b1}})) begin
                err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (err_s > max_err_r) begin
                max_err_r <= err_s;
            end
        end
    end
endmodule

// File: tb/tb_approx_add_pipe.sv
// Directed self-checking bench for approx_add_pipe: main config (W8,K4,S2), a CNT_W=4 copy
// for counter saturation, and a K=0 copy that must always be exact.
module tb_approx_add_pipe;
    logic clk = 1'b0;
    logic rst;
    logic clr0, clr1, clr2;
    logic [8:0] max0, max1, max2;
    logic [15:0] errc0, txn0;
    logic [3:0]  errc1, txn1;
    logic [15:0] errc2, txn2;
    int checks = 0;
    int failures = 0;

    approx_add_if #(.WIDTH(8)) b0 ();
    approx_add_if #(.WIDTH(8)) b1 ();
    approx_add_if #(.WIDTH(8)) b2 ();

    approx_add_pipe #(.WIDTH(8), .APPROX_BITS(4), .STAGES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(b0), .clear_stats(clr0),
        .max_err(max0), .err_cnt(errc0), .txn_cnt(txn0));

    approx_add_pipe #(.WIDTH(8), .APPROX_BITS(4), .STAGES(2), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .bus(b1), .clear_stats(clr1),
        .max_err(max1), .err_cnt(errc1), .txn_cnt(txn1));

    approx_add_pipe #(.WIDTH(8), .APPROX_BITS(0), .STAGES(2), .CNT_W(16)) dut_k0 (
        .clk(clk), .rst(rst), .bus(b2), .clear_stats(clr2),
        .max_err(max2), .err_cnt(errc2), .txn_cnt(txn2));

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", b0.out_valid); end
        checks++; if (b0.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", b0.in_ready); end
        checks++; if (b0.O !== 9'h000) begin failures++; $display("FAIL reset_O got=%h exp=000", b0.O); end
        checks++; if (b0.out_err !== 9'h000) begin failures++; $display("FAIL reset_out_err got=%h exp=000", b0.out_err); end
        checks++; if (txn0 !== 16'd0 || errc0 !== 16'd0 || max0 !== 9'd0) begin
            failures++; $display("FAIL reset_stats got txn=%0d err=%0d max=%0d exp=0/0/0", txn0, errc0, max0); end
    endtask

    task automatic test_approx();
        logic [7:0] av [3] = '{8'h0F, 8'hFF, 8'h08};
        logic [7:0] bv [3] = '{8'h01, 8'hFF, 8'h08};
        logic [8:0] eo [3] = '{9'h00F, 9'h1FF, 9'h018};
        logic [8:0] ee [3] = '{9'd1, 9'd1, 9'd8};
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            b0.A = av[j]; b0.B = bv[j]; b0.mode = 1'b1; b0.in_valid = 1'b1;
            @(posedge clk); #1;
            b0.in_valid = 1'b0;
            checks++; if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL approx_early[%0d] got=%b exp=0", j, b0.out_valid); end
            @(posedge clk); #1;
            checks++; if (b0.out_valid !== 1'b1) begin failures++; $display("FAIL approx_valid[%0d] got=%b exp=1", j, b0.out_valid); end
            checks++; if (b0.O !== eo[j]) begin failures++; $display("FAIL approx_O[%0d] got=%h exp=%h", j, b0.O, eo[j]); end
            checks++; if (b0.out_err !== ee[j]) begin failures++; $display("FAIL approx_err[%0d] got=%0d exp=%0d", j, b0.out_err, ee[j]); end
        end
        @(posedge clk); #1;
        checks++; if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL approx_dup got=%b exp=0", b0.out_valid); end
        checks++; if (txn0 !== 16'd3 || errc0 !== 16'd3 || max0 !== 9'd8) begin
            failures++; $display("FAIL approx_stats got txn=%0d err=%0d max=%0d exp=3/3/8", txn0, errc0, max0); end
    endtask

    task automatic test_exact();
        logic [7:0] av [3] = '{8'h0F, 8'hFF, 8'h08};
        logic [7:0] bv [3] = '{8'h01, 8'hFF, 8'h08};
        logic [8:0] eo [3] = '{9'h010, 9'h1FE, 9'h010};
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            b0.A = av[j]; b0.B = bv[j]; b0.mode = 1'b0; b0.in_valid = 1'b1;
            @(posedge clk); #1;
            b0.in_valid = 1'b0;
            @(posedge clk); #1;
            checks++; if (b0.out_valid !== 1'b1) begin failures++; $display("FAIL exact_valid[%0d] got=%b exp=1", j, b0.out_valid); end
            checks++; if (b0.O !== eo[j]) begin failures++; $display("FAIL exact_O[%0d] got=%h exp=%h", j, b0.O, eo[j]); end
            checks++; if (b0.out_err !== 9'd0) begin failures++; $display("FAIL exact_err[%0d] got=%0d exp=0", j, b0.out_err); end
        end
        @(posedge clk); #1;
        checks++; if (txn0 !== 16'd6 || errc0 !== 16'd3 || max0 !== 9'd8) begin
            failures++; $display("FAIL exact_stats got txn=%0d err=%0d max=%0d exp=6/3/8", txn0, errc0, max0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] av [8] = '{8'h0F, 8'h0F, 8'h08, 8'hFF, 8'hFF, 8'h12, 8'h12, 8'h30};
        logic [7:0] bv [8] = '{8'h01, 8'h01, 8'h08, 8'hFF, 8'hFF, 8'h34, 8'h34, 8'h05};
        logic [8:0] eo [8] = '{9'h00F, 9'h010, 9'h018, 9'h1FE, 9'h1FF, 9'h046, 9'h042, 9'h035};
        logic [8:0] ee [8] = '{9'd1, 9'd0, 9'd8, 9'd0, 9'd1, 9'd0, 9'd4, 9'd0};
        @(posedge clk); #1 clr0 = 1'b1;
        @(posedge clk); #1 clr0 = 1'b0;
        checks++; if (txn0 !== 16'd0 || errc0 !== 16'd0 || max0 !== 9'd0) begin
            failures++; $display("FAIL clear_stats got txn=%0d err=%0d max=%0d exp=0/0/0", txn0, errc0, max0); end
        for (int k = 0; k < 11; k++) begin
            @(posedge clk); #1;
            if (k >= 2 && k < 10) begin
                checks++; if (b0.out_valid !== 1'b1 || b0.O !== eo[k-2] || b0.out_err !== ee[k-2]) begin
                    failures++; $display("FAIL b2b_beat[%0d] got v=%b O=%h err=%0d exp v=1 O=%h err=%0d",
                        k-2, b0.out_valid, b0.O, b0.out_err, eo[k-2], ee[k-2]); end
            end else begin
                checks++; if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle[%0d] got=%b exp=0", k, b0.out_valid); end
            end
            if (k < 8) begin
                b0.A = av[k]; b0.B = bv[k]; b0.mode = (k % 2 == 0); b0.in_valid = 1'b1;
            end else begin
                b0.in_valid = 1'b0;
            end
        end
        checks++; if (txn0 !== 16'd8 || errc0 !== 16'd4 || max0 !== 9'd8) begin
            failures++; $display("FAIL b2b_stats got txn=%0d err=%0d max=%0d exp=8/4/8", txn0, errc0, max0); end
    endtask

    task automatic test_stall();
        int idx = 0;
        int delivered = 0;
        bit stalled = 1'b0;
        logic [8:0] held = 9'h000;
        logic [8:0] e;
        logic [8:0] exp_q [$];
        for (int k = 0; k < 24; k++) begin
            @(posedge clk); #1;
            b0.out_ready = !(k >= 3 && k < 8);
            b0.in_valid  = (idx < 8);
            b0.A = 8'h13 + 8'(idx * 16); b0.B = 8'hF0; b0.mode = 1'b0;
            #1;
            if (stalled) begin
                checks++; if (b0.out_valid !== 1'b1 || b0.O !== held) begin
                    failures++; $display("FAIL stall_hold[%0d] got v=%b O=%h exp v=1 O=%h", k, b0.out_valid, b0.O, held); end
            end
            checks++; if (b0.in_ready !== !(k >= 3 && k < 8)) begin
                failures++; $display("FAIL stall_in_ready[%0d] got=%b exp=%b", k, b0.in_ready, !(k >= 3 && k < 8)); end
            if (b0.in_valid && b0.in_ready) begin
                exp_q.push_back({1'b0, b0.A} + {1'b0, b0.B});
                idx++;
            end
            if (b0.out_valid && b0.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL stall_extra[%0d] got O=%h exp none", k, b0.O);
                end else begin
                    e = exp_q.pop_front();
                    if (b0.O !== e) begin failures++; $display("FAIL stall_order[%0d] got=%h exp=%h", k, b0.O, e); end
                end
                delivered++;
            end
            stalled = b0.out_valid && !b0.out_ready;
            held = b0.O;
        end
        b0.in_valid = 1'b0; b0.out_ready = 1'b1;
        checks++; if (delivered != 8) begin failures++; $display("FAIL stall_count got=%0d exp=8", delivered); end
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            b1.A = 8'h08; b1.B = 8'h08; b1.mode = 1'b1; b1.in_valid = 1'b1;
        end
        @(posedge clk); #1 b1.in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++; if (txn1 !== 4'd15 || errc1 !== 4'd15 || max1 !== 9'd8) begin
            failures++; $display("FAIL sat_full got txn=%0d err=%0d max=%0d exp=15/15/8", txn1, errc1, max1); end
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            b1.in_valid = 1'b1;
        end
        @(posedge clk); #1 b1.in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++; if (txn1 !== 4'd15 || errc1 !== 4'd15) begin
            failures++; $display("FAIL sat_hold got txn=%0d err=%0d exp=15/15", txn1, errc1); end
        @(posedge clk); #1 b1.in_valid = 1'b1;
        @(posedge clk); #1 b1.in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (b1.out_valid !== 1'b1) begin failures++; $display("FAIL sat_clear_beat got=%b exp=1", b1.out_valid); end
        clr1 = 1'b1;
        @(posedge clk); #1 clr1 = 1'b0;
        checks++; if (txn1 !== 4'd0 || errc1 !== 4'd0 || max1 !== 9'd0) begin
            failures++; $display("FAIL sat_clear got txn=%0d err=%0d max=%0d exp=0/0/0", txn1, errc1, max1); end
    endtask

    task automatic test_midreset();
        @(posedge clk); #1;
        b0.A = 8'h0F; b0.B = 8'h01; b0.mode = 1'b1; b0.in_valid = 1'b1;
        @(posedge clk); #1;
        b0.A = 8'h08; b0.B = 8'h08;
        @(posedge clk); #1;
        b0.in_valid = 1'b0;
        checks++; if (b0.out_valid !== 1'b1) begin failures++; $display("FAIL midrst_inflight got=%b exp=1", b0.out_valid); end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        checks++; if (b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1 || b0.O !== 9'h000) begin
            failures++; $display("FAIL midrst_pipe got v=%b rdy=%b O=%h exp v=0 rdy=1 O=000", b0.out_valid, b0.in_ready, b0.O); end
        checks++; if (txn0 !== 16'd0 || errc0 !== 16'd0 || max0 !== 9'd0) begin
            failures++; $display("FAIL midrst_stats got txn=%0d err=%0d max=%0d exp=0/0/0", txn0, errc0, max0); end
        repeat (2) begin
            @(posedge clk); #1;
            checks++; if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_partial got=%b exp=0", b0.out_valid); end
        end
    endtask

    task automatic test_k0();
        logic [7:0] av [6];
        logic [7:0] bv [6];
        logic [8:0] eo [6];
        av[0] = 8'hFF; bv[0] = 8'hFF;
        av[1] = 8'h0F; bv[1] = 8'h01;
        av[2] = 8'h08; bv[2] = 8'h08;
        for (int i = 3; i < 6; i++) begin
            av[i] = 8'($urandom_range(0, 255));
            bv[i] = 8'($urandom_range(0, 255));
        end
        for (int i = 0; i < 6; i++) eo[i] = {1'b0, av[i]} + {1'b0, bv[i]};
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            if (k >= 2 && k < 8) begin
                checks++; if (b2.out_valid !== 1'b1 || b2.O !== eo[k-2] || b2.out_err !== 9'd0) begin
                    failures++; $display("FAIL k0_beat[%0d] got v=%b O=%h err=%0d exp v=1 O=%h err=0",
                        k-2, b2.out_valid, b2.O, b2.out_err, eo[k-2]); end
            end
            if (k < 6) begin
                b2.A = av[k]; b2.B = bv[k]; b2.mode = (k % 2 == 0); b2.in_valid = 1'b1;
            end else begin
                b2.in_valid = 1'b0;
            end
        end
        checks++; if (txn2 !== 16'd6 || errc2 !== 16'd0 || max2 !== 9'd0) begin
            failures++; $display("FAIL k0_stats got txn=%0d err=%0d max=%0d exp=6/0/0", txn2, errc2, max2); end
    endtask

    initial begin
        rst = 1'b1;
        clr0 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
        b0.in_valid = 1'b0; b0.A = 8'h00; b0.B = 8'h00; b0.mode = 1'b0; b0.out_ready = 1'b1;
        b1.in_valid = 1'b0; b1.A = 8'h00; b1.B = 8'h00; b1.mode = 1'b0; b1.out_ready = 1'b1;
        b2.in_valid = 1'b0; b2.A = 8'h00; b2.B = 8'h00; b2.mode = 1'b0; b2.out_ready = 1'b1;
        test_reset();
        test_approx();
        test_exact();
        test_back_to_back();
        test_stall();
        test_saturation();
        test_midreset();
        test_k0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
